// File: rtl/mmio_pkg.sv
// Shared constants and register decode for the 0xFFF0-0xFFFF MMIO window.
package mmio_pkg;

    localparam logic [3:0] OFF_KDATA = 4'h0;
    localparam logic [3:0] OFF_SDATA = 4'h2;
    localparam logic [3:0] OFF_KEDGE = 4'h4;
    localparam logic [3:0] OFF_TIMER = 4'h6;
    localparam logic [3:0] OFF_HEX   = 4'h8;
    localparam logic [3:0] OFF_LEDR  = 4'hA;
    localparam logic [3:0] OFF_LEDG  = 4'hC;

    localparam logic [15:0] UNMAPPED_VAL = 16'hDEAD;

    // Encoding equals ADDR[3:1] so the decode is a plain cast.
    typedef enum logic [2:0] {
        REG_KDATA    = 3'd0,
        REG_SDATA    = 3'd1,
        REG_KEDGE    = 3'd2,
        REG_TIMER    = 3'd3,
        REG_HEX      = 3'd4,
        REG_LEDR     = 3'd5,
        REG_LEDG     = 3'd6,
        REG_UNMAPPED = 3'd7
    } mmio_reg_e;

    function automatic mmio_reg_e reg_decode(input logic [2:0] addr_hi);
        return mmio_reg_e'(addr_hi);
    endfunction

endpackage

// File: rtl/mmio_ctrl_if.sv
// Data-memory side bus of the MMIO controller; the CPU is the master.
interface mmio_ctrl_if #(
    parameter int DBITS = 16
);
    logic [DBITS-1:0] ADDR;
    logic [DBITS-1:0] WDATA;
    logic             WE;
    logic [DBITS-1:0] RDATA;
    logic             HIT;

    modport master (output ADDR, output WDATA, output WE, input RDATA, input HIT);
    modport slave  (input ADDR, input WDATA, input WE, output RDATA, output HIT);
endinterface

// File: rtl/mmio_debounce.sv
// One input channel: 2-flop synchroniser followed by a stable-run debounce counter.
module mmio_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic IN,
    output logic OUT,
    output logic RISE
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // RISE is combinational so the sticky flag lands on the same edge as the state.
    always_comb begin
        sync1_d = IN;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = '0;
        RISE    = 1'b0;
        if (sync2_q != state_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                state_d = sync2_q;
                RISE    = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign OUT = state_q;

endmodule

// File: rtl/mmio_ctrl.sv
// MMIO controller for the 16-bit CPU: debounced KEY/SW, sticky key flags, LED/HEX stores.
// Optional free-running timer at +6 is built only when MMIO_TIMER_EN is defined.
module mmio_ctrl
    import mmio_pkg::*;
#(
    parameter int               DBITS           = 16,
    parameter int               NKEYS           = 4,
    parameter int               NSW             = 10,
    parameter int               NLEDR           = 10,
    parameter int               NLEDG           = 8,
    parameter int               DEBOUNCE_CYCLES = 250000,
    parameter int               TICK_CYCLES     = 50000,
    parameter logic [DBITS-1:0] BASE            = 16'hFFF0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    mmio_ctrl_if.slave       bus,
    input  logic [NKEYS-1:0] KEY,
    input  logic [NSW-1:0]   SW,
    output logic [DBITS-1:0] HEX_OUT,
    output logic [NLEDR-1:0] LEDR_OUT,
    output logic [NLEDG-1:0] LEDG_OUT
);
    localparam int NCH = NKEYS + NSW;

    logic [NCH-1:0]   raw_in, deb, rise;
    logic [NKEYS-1:0] key_deb, key_rise;
    logic [NSW-1:0]   sw_deb;

    // Keys are active-low at the pins; flip them so 1 means pressed everywhere inside.
    assign raw_in = {SW, ~KEY};

    for (genvar i = 0; i < NCH; i++) begin : g_deb
        mmio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .CLK     (CLK),
            .RESET_N (RESET_N),
            .IN      (raw_in[i]),
            .OUT     (deb[i]),
            .RISE    (rise[i])
        );
    end

    assign key_deb  = deb[NKEYS-1:0];
    assign key_rise = rise[NKEYS-1:0];
    assign sw_deb   = deb[NCH-1:NKEYS];

    logic unused_bits;
    assign unused_bits = ^{bus.ADDR[0], rise[NCH-1:NKEYS]};

    logic      hit, wr_en;
    mmio_reg_e sel;

    assign hit     = (bus.ADDR[DBITS-1:4] == BASE[DBITS-1:4]);
    assign bus.HIT = hit;
    assign wr_en   = bus.WE && hit;
    assign sel     = reg_decode(bus.ADDR[3:1]);

    logic [DBITS-1:0] timer_rd;

`ifdef MMIO_TIMER_EN
    localparam int PW = $clog2(TICK_CYCLES + 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [DBITS-1:0] timer_q, timer_d;

    // A CPU load overrides a tick that lands on the same edge.
    always_comb begin
        presc_d = presc_q + PW'(1);
        timer_d = timer_q;
        if (presc_q == PW'(TICK_CYCLES - 1)) begin
            presc_d = '0;
            timer_d = timer_q + DBITS'(1);
        end
        if (wr_en && sel == REG_TIMER) begin
            presc_d = '0;
            timer_d = bus.WDATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            presc_q <= '0;
            timer_q <= '0;
        end else begin
            presc_q <= presc_d;
            timer_q <= timer_d;
        end
    end

    assign timer_rd = timer_q;
`else
    assign timer_rd = DBITS'(UNMAPPED_VAL);
`endif

    logic [NKEYS-1:0] kedge_q, kedge_d;
    logic [DBITS-1:0] hex_q, hex_d;
    logic [NLEDR-1:0] ledr_q, ledr_d;
    logic [NLEDG-1:0] ledg_q, ledg_d;
    logic [DBITS-1:0] rdata_q, rdata_d;

    always_comb begin
        kedge_d = kedge_q;
        hex_d   = hex_q;
        ledr_d  = ledr_q;
        ledg_d  = ledg_q;
        rdata_d = '0;

        if (wr_en) begin
            case (sel)
                REG_KEDGE: kedge_d = kedge_q & ~bus.WDATA[NKEYS-1:0];
                REG_HEX:   hex_d   = bus.WDATA;
                REG_LEDR:  ledr_d  = bus.WDATA[NLEDR-1:0];
                REG_LEDG:  ledg_d  = bus.WDATA[NLEDG-1:0];
                default:   ;
            endcase
        end
        // Applied after the clear so a press on the clearing edge is not lost.
        kedge_d = kedge_d | key_rise;

        case (sel)
            REG_KDATA: rdata_d = DBITS'(key_deb);
            REG_SDATA: rdata_d = DBITS'(sw_deb);
            REG_KEDGE: rdata_d = DBITS'(kedge_q);
            REG_TIMER: rdata_d = timer_rd;
            REG_HEX:   rdata_d = hex_q;
            REG_LEDR:  rdata_d = DBITS'(ledr_q);
            REG_LEDG:  rdata_d = DBITS'(ledg_q);
            default:   rdata_d = DBITS'(UNMAPPED_VAL);
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            kedge_q <= '0;
            hex_q   <= '0;
            ledr_q  <= '0;
            ledg_q  <= '0;
            rdata_q <= '0;
        end else begin
            kedge_q <= kedge_d;
            hex_q   <= hex_d;
            ledr_q  <= ledr_d;
            ledg_q  <= ledg_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.RDATA = rdata_q;
    assign HEX_OUT   = hex_q;
    assign LEDR_OUT  = ledr_q;
    assign LEDG_OUT  = ledg_q;

endmodule

// File: doc/mmio_ctrl.md
# mmio_ctrl

Parametrised memory-mapped I/O controller for the 16-bit processor's `0xFFF0`–`0xFFFF` window. It replaces the ad-hoc KEY/SW read mux and HEX/LEDR/LEDG store logic in the processor top level. It adds per-channel input synchronisation and debounce, sticky key-press flags with write-1-to-clear, and an optional free-running timer. The CPU's data-memory port drives it in parallel with the memory array and muxes `RDATA` when `HIT` is set.

## Interface
- `DBITS`, 16, data/address width
- `NKEYS`, 4, number of push-button inputs
- `NSW`, 10, number of switch inputs
- `NLEDR`, 10, red LED output width
- `NLEDG`, 8, green LED output width
- `DEBOUNCE_CYCLES`, 250000, consecutive stable cycles needed to accept an input change (≥1)
- `TICK_CYCLES`, 50000, clock cycles per timer increment (≥1)
- `BASE`, 16'hFFF0, window base; low 4 bits must be 0
- `CLK` input 1: single clock, all state on posedge
- `RESET_N` input 1: asynchronous, active-low reset
- `ADDR` input DBITS: data-memory address
- `WDATA` input DBITS: store data
- `WE` input 1: store strobe
- `RDATA` output DBITS: registered read data
- `HIT` output 1: combinational, `ADDR[DBITS-1:4]==BASE[DBITS-1:4]`
- `KEY` input NKEYS: raw buttons, low = pressed
- `SW` input NSW: raw switches
- `HEX_OUT` output DBITS: value for the seven-segment decoders
- `LEDR_OUT` output NLEDR: red LEDs
- `LEDG_OUT` output NLEDG: green LEDs

## Operation
- Register map is selected by `ADDR[3:1]`; `ADDR[0]` is ignored.
  - +0 KDATA (RO): debounced keys, 1 = pressed
  - +2 SDATA (RO): debounced switches
  - +4 KEDGE (R/W1C): sticky press flags
  - +6 TIMER (R/W)
  - +8 HEX (R/W)
  - +A LEDR (R/W)
  - +C LEDG (R/W)
  - +E reads 16'hDEAD, writes ignored
- Writes take effect only when `WE && HIT`. Narrow registers take the low bits of `WDATA`; readback is zero-extended.
- Input path, per channel:
  - 2-flop synchroniser feeds a debounce counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If the synchronised input equals the debounced state, the counter clears.
  - Otherwise the counter increments. On reaching `DEBOUNCE_CYCLES` the debounced state toggles and the counter clears.
  - KEY is inverted before the synchroniser.
- KEDGE bit i is set on a debounced key 0→1 transition.
  - Writing 1 to a bit clears it; writing 0 leaves it unchanged.
  - If set and clear happen in the same cycle, set wins.
- TIMER:
  - A prescaler counts 0..`TICK_CYCLES`-1. On wrap, TIMER increments, wrapping from 2^DBITS−1 to 0.
  - A TIMER write loads `WDATA` and clears the prescaler. A write in the same cycle as a tick wins.
- Reset values (asynchronous): `RDATA`, `HEX_OUT`, `LEDR_OUT`, `LEDG_OUT`, KEDGE, TIMER, prescaler, synchronisers, debounce counters and debounced states all 0.
- Reset asserted mid-debounce discards the partial count. Reset mid-operation otherwise simply returns all state to the reset values.

## Timing
- Read latency is 1 cycle: `RDATA` is registered every cycle from the decode of the current `ADDR`.
- When `HIT`=0, `RDATA` is don't-care (the CPU muxes on `HIT`), but it must still be driven.
- A read of a register in the same cycle it is written returns the old value.
- Outputs (`HEX_OUT`, `LEDR_OUT`, `LEDG_OUT`) change on the edge where the write is sampled.
- Input-to-KDATA/SDATA latency is exactly `DEBOUNCE_CYCLES`+2 cycles for a clean step: 2 synchroniser cycles plus `DEBOUNCE_CYCLES`.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles produces no change.
- After reset, a switch held high reads 0 until `DEBOUNCE_CYCLES`+2 cycles have elapsed.
- The KEDGE flag is visible on the same edge the debounced state rises.

## Configuration
- `MMIO_TIMER_EN`
  - Defined: prescaler and TIMER are implemented as above.
  - Undefined: no timer logic is synthesised, +6 reads 16'hDEAD and writes to it are ignored.

## Structure
- Package `mmio_pkg`:
  - register offset constants (`OFF_KDATA` … `OFF_LEDG`)
  - `UNMAPPED_VAL` = 16'hDEAD
  - `mmio_reg_e` enum over `ADDR[3:1]`
- Sub-module `mmio_debounce`:
  - one instance per channel, generate-looped over `NKEYS`+`NSW`
  - parameter `DEBOUNCE_CYCLES`; ports `CLK`, `RESET_N`, `IN`, `OUT`, `RISE`
  - contains the synchroniser and the counter

## Test plan
- Sim parameters `DEBOUNCE_CYCLES`=4, `TICK_CYCLES`=3.
- Hold SW=10'h155 after reset → SDATA reads 16'h0000 at cycle 5 and 16'h0155 from cycle 6 onward.
- Pulse KEY[1] low for 3 cycles → KDATA and KEDGE stay 0. Hold KEY[1] low for 10 cycles → KDATA=0002 and KEDGE=0002; release → KDATA=0 and KEDGE remains 0002.
- Write KEDGE=0002 on the same cycle a new KEY[1] press debounces → KEDGE stays 0002. Write again with no press → 0000.
- Write 0xFFF8=16'hBEEF, 0xFFFA=16'h03FF, 0xFFFC=16'h1234 → outputs BEEF/3FF/34 next cycle. Readbacks return BEEF, 03FF, 0034. Read of 0xFFFE returns DEAD.
- Write TIMER=16'hFFFF → after 3 cycles TIMER=0000, after 6 cycles 0001. Assert RESET_N low mid-count → all outputs and TIMER are 0 immediately. With `MMIO_TIMER_EN` undefined, 0xFFF6 reads DEAD.
